sd_cmd_tx: RTL and testbench
============================

# sd_cmd_tx

Serialises one SD-bus command frame (start bit, transmission bit, 6-bit index, 32-bit argument, CRC7, end bit; 48 bits, MSB first) onto the card CMD line. It sits directly downstream of the SD clock generator and consumes its falling-edge strobe, so every CMD-line transition is paced to the card clock while the block itself runs entirely on the system clock. It feeds the command/response controller and uses a valid/ready handshake.

## Interface
- `GAP_BITS`, default 8: number of idle card-clock periods (Ncc) the block waits after the end bit before it accepts the next command. Legal range is 0–255.

- `clk` in 1: system clock.
- `res` in 1: synchronous, active-high reset.
- `sd_clk_fall` in 1: one-`clk` pulse marking a falling edge of the SD clock. All CMD-line updates happen only on these cycles.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the block can accept a command. Reset value 1.
- `cmd_index` in 6: command index. Sampled only at the handshake.
- `cmd_arg` in 32: command argument. Sampled only at the handshake.
- `cmd_out` out 1: CMD line data. Reset value 1 (idle high).
- `cmd_oe` out 1: CMD line output enable. Reset value 0.
- `busy` out 1: high whenever the state is not IDLE. Reset value 0.
- `done` out 1: one-cycle pulse when the frame and gap are complete. Reset value 0.

## Operation
- **States and transitions:**
  - IDLE → WAIT on acceptance.
  - WAIT → SHIFT on the first strobe after acceptance.
  - SHIFT → GAP, or → IDLE directly when `GAP_BITS`=0.
  - GAP → IDLE.
- **Acceptance:** happens when `cmd_valid` && `cmd_ready`. `cmd_ready` = (state==IDLE).
  - The frame is latched as {0, 1, `cmd_index`, `cmd_arg`}.
  - The bit counter and CRC register are cleared.
- **Strobe numbering:** strobes are counted after acceptance. A strobe in the acceptance cycle itself does not count.
  - Strobe k (k = 1..48) drives frame bit k−1 with `cmd_oe`=1.
  - Bits 0–39 come from the latched frame. Each of these bits is also shifted into CRC7 (polynomial x^7+x^3+1, init 0).
  - Bits 40–46 are CRC[6:0], MSB first.
  - Bit 47 is 1.
- **Release:** strobe 49 sets `cmd_oe`=0 and `cmd_out`=1.
- **Gap:** the block counts `GAP_BITS` further strobes with the line released.
  - `done` fires on the last counted strobe.
  - If `GAP_BITS`=0, `done` fires on strobe 49.
  - The state returns to IDLE on the same edge as `done`.
- **Ignored inputs:**
  - Strobes in IDLE are ignored.
  - `cmd_valid` while busy is ignored. The upstream must hold the command until `cmd_ready`.
- **Reset mid-frame:** `res` aborts immediately. On the next `clk` edge all outputs take their reset values, and no `done` is produced.

## Timing
- All outputs are registered. `cmd_out` and `cmd_oe` change on the `clk` edge where `sd_clk_fall`=1 and are visible the following cycle.
- **Latency:** from acceptance to the start bit on the line is 1 strobe plus 1 `clk`.
- **Total duration:** from acceptance to `done` is 49+`GAP_BITS` strobes.
- `done` is high for exactly one `clk` cycle. `cmd_ready` is high in the same cycle, so back-to-back acceptance is possible in that cycle.
- **CRC timing:** the CRC register updates on strobes 1–40 only, so it is final before strobe 41 drives CRC[6].
- **Simultaneous events:** if `res` and a strobe occur in the same cycle, `res` wins.

## Configuration
- **`SD_CMD_TX_CNT_EN` defined:** adds output `tx_count` (16 bits, reset 0).
  - It increments on each `done` and wraps from 0xFFFF to 0.
- **`SD_CMD_TX_CNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Package `sd_pkg`:**
  - `SD_CMD_FRAME_LEN`=48
  - `SD_CRC7_POLY`=7'h09
  - `SD_CMD_ARG_W`=32
  - `SD_CMD_IDX_W`=6
  - typedef enum `sd_cmd_tx_state_t` {IDLE, WAIT, SHIFT, GAP}
- **Sub-module `sd_crc7`:** serial CRC7 with ports `clk`, `res`, `clr`, `en`, `din` and output `crc[6:0]`. It is reused later by the response receiver.

## Test plan
- CMD0, arg 0x00000000, strobe every 4 clk → line carries 0x40_00000000_95; `done` arrives after 57 strobes (`GAP_BITS`=8).
- CMD8, arg 0x000001AA → line carries 0x48_000001AA_87; CRC field equals 0x43.
- CMD17, arg 0, with a strobe in the acceptance cycle → that strobe is ignored; the start bit appears on the next strobe; the last byte is 0x55.
- `res` asserted at strobe 20 of CMD55 → next cycle `cmd_oe`=0, `cmd_out`=1, `cmd_ready`=1, no `done`; a following CMD0 transmits correctly.
- `GAP_BITS`=0, two commands with `cmd_valid` held high → second start bit occurs at strobe 50 relative to the first acceptance; `tx_count`=2 with `SD_CMD_TX_CNT_EN`.
- `cmd_arg` and `cmd_index` changed while busy → the transmitted frame is unchanged; `cmd_ready` stays 0 until `done`.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared SD-bus constants, the command transmitter state type and a serial CRC7 step.
package sd_pkg;

    localparam int unsigned SD_CMD_FRAME_LEN = 48;
    localparam logic [6:0]  SD_CRC7_POLY     = 7'h09;
    localparam int unsigned SD_CMD_ARG_W     = 32;
    localparam int unsigned SD_CMD_IDX_W     = 6;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SHIFT,
        GAP
    } sd_cmd_tx_state_t;

    function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), MSB-first input; shared by the command transmitter and response receiver.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] r_crc;

    always_ff @(posedge clk) begin
        if (res || clr) begin
            r_crc <= '0;
        end else if (en) begin
            r_crc <= sd_crc7_step(r_crc, din);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/sd_cmd_tx.sv
// SD command frame serialiser paced by the SD clock falling-edge strobe.
// Optional SD_CMD_TX_CNT_EN adds a 16-bit count of completed frames (tx_count).
module sd_cmd_tx
    import sd_pkg::*;
#(
    parameter int unsigned GAP_BITS = 8
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    sd_clk_fall,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [SD_CMD_IDX_W-1:0] cmd_index,
    input  logic [SD_CMD_ARG_W-1:0] cmd_arg,
    output logic                    cmd_out,
    output logic                    cmd_oe,
    output logic                    busy,
    output logic                    done
`ifdef SD_CMD_TX_CNT_EN
    ,
    output logic [15:0]             tx_count
`endif
);

    localparam int unsigned BODY_BITS = SD_CMD_IDX_W + SD_CMD_ARG_W + 2;
    localparam logic [5:0]  CRC_BIT   = 6'(BODY_BITS);
    localparam logic [5:0]  LAST_BIT  = 6'(SD_CMD_FRAME_LEN);
    localparam logic [7:0]  GAP_LAST  = 8'((GAP_BITS == 0) ? 0 : GAP_BITS - 1);

    sd_cmd_tx_state_t       r_state, w_state_nxt;
    logic [BODY_BITS-1:0]   r_frame, w_frame_nxt;
    logic [5:0]             r_bitcnt, w_bitcnt_nxt;
    logic [7:0]             r_gapcnt, w_gapcnt_nxt;
    logic                   r_out, w_out_nxt;
    logic                   r_oe, w_oe_nxt;
    logic                   r_done, w_done_nxt;
    logic                   w_crc_clr, w_crc_en, w_crc_din;
    logic [6:0]             w_crc;

    sd_crc7 u_crc (
        .clk (clk),
        .res (res),
        .clr (w_crc_clr),
        .en  (w_crc_en),
        .din (w_crc_din),
        .crc (w_crc)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            r_state  <= IDLE;
            r_frame  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_out    <= 1'b1;
            r_oe     <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_frame  <= w_frame_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gapcnt <= w_gapcnt_nxt;
            r_out    <= w_out_nxt;
            r_oe     <= w_oe_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_frame_nxt  = r_frame;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        w_out_nxt    = r_out;
        w_oe_nxt     = r_oe;
        w_done_nxt   = 1'b0;
        w_crc_clr    = 1'b0;
        w_crc_en     = 1'b0;
        w_crc_din    = r_frame[BODY_BITS-1];

        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt  = WAIT;
                    w_frame_nxt  = {1'b0, 1'b1, cmd_index, cmd_arg};
                    w_bitcnt_nxt = '0;
                    w_gapcnt_nxt = '0;
                    w_crc_clr    = 1'b1;
                end
            end
            WAIT, SHIFT: begin
                if (sd_clk_fall) begin
                    w_state_nxt  = SHIFT;
                    w_bitcnt_nxt = r_bitcnt + 6'd1;
                    if (r_bitcnt < CRC_BIT) begin
                        w_out_nxt   = r_frame[BODY_BITS-1];
                        w_oe_nxt    = 1'b1;
                        w_frame_nxt = {r_frame[BODY_BITS-2:0], 1'b0};
                        w_crc_en    = 1'b1;
                    end else if (r_bitcnt == CRC_BIT) begin
                        // Reload the emptied shifter with CRC[5:0] and the end bit so the tail shares the shift path
                        w_out_nxt   = w_crc[6];
                        w_oe_nxt    = 1'b1;
                        w_frame_nxt = {w_crc[5:0], 1'b1, {(BODY_BITS-7){1'b0}}};
                    end else if (r_bitcnt < LAST_BIT) begin
                        w_out_nxt   = r_frame[BODY_BITS-1];
                        w_oe_nxt    = 1'b1;
                        w_frame_nxt = {r_frame[BODY_BITS-2:0], 1'b0};
                    end else begin
                        w_out_nxt = 1'b1;
                        w_oe_nxt  = 1'b0;
                        if (GAP_BITS == 0) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (sd_clk_fall) begin
                    w_gapcnt_nxt = r_gapcnt + 8'd1;
                    if (r_gapcnt == GAP_LAST) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign cmd_out   = r_out;
    assign cmd_oe    = r_oe;
    assign done      = r_done;

`ifdef SD_CMD_TX_CNT_EN
    logic [15:0] r_tx_count;

    always_ff @(posedge clk) begin
        if (res) begin
            r_tx_count <= '0;
        end else if (w_done_nxt) begin
            r_tx_count <= r_tx_count + 16'd1;
        end
    end

    assign tx_count = r_tx_count;
`endif

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed scoreboard bench for sd_cmd_tx: one GAP_BITS=8 instance and one GAP_BITS=0 instance.
module tb_sd_cmd_tx;

    logic        clk;
    logic        res;
    logic        sd_clk_fall;

    logic        cmd_valid, cmd_ready, cmd_out, cmd_oe, busy, done;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;

    logic        cmd_valid_b, cmd_ready_b, cmd_out_b, cmd_oe_b, busy_b, done_b;
    logic [5:0]  cmd_index_b;
    logic [31:0] cmd_arg_b;

`ifdef SD_CMD_TX_CNT_EN
    logic [15:0] tx_count, tx_count_b;
`endif

    int vectors;
    int miscompares;
    logic q_bits[$];

    sd_cmd_tx #(.GAP_BITS(8)) dut (
        .clk         (clk),
        .res         (res),
        .sd_clk_fall (sd_clk_fall),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_index   (cmd_index),
        .cmd_arg     (cmd_arg),
        .cmd_out     (cmd_out),
        .cmd_oe      (cmd_oe),
        .busy        (busy),
        .done        (done)
`ifdef SD_CMD_TX_CNT_EN
        ,
        .tx_count    (tx_count)
`endif
    );

    sd_cmd_tx #(.GAP_BITS(0)) dut_b (
        .clk         (clk),
        .res         (res),
        .sd_clk_fall (sd_clk_fall),
        .cmd_valid   (cmd_valid_b),
        .cmd_ready   (cmd_ready_b),
        .cmd_index   (cmd_index_b),
        .cmd_arg     (cmd_arg_b),
        .cmd_out     (cmd_out_b),
        .cmd_oe      (cmd_oe_b),
        .busy        (busy_b),
        .done        (done_b)
`ifdef SD_CMD_TX_CNT_EN
        ,
        .tx_count    (tx_count_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] crc7_model(input logic [39:0] d);
        logic [6:0] c;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'b0001001;
            else             c = {c[5:0], 1'b0};
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Three idle clocks then one strobe clock; returns #1 after the strobe edge.
    task automatic strobe(input bit with_res);
        repeat (3) @(posedge clk);
        #1;
        sd_clk_fall = 1'b1;
        res         = with_res;
        @(posedge clk);
        #1;
        sd_clk_fall = 1'b0;
        res         = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                             input bit acc_strobe, input int abort_at,
                             input logic [47:0] exp_frame, output logic [47:0] got);
        logic [39:0] body;
        logic [47:0] model;
        logic        exp_bit;
        int          done_n;
        bit          ready_bad;
        body  = {2'b01, idx, arg};
        model = {body, crc7_model(body), 1'b1};
        for (int i = 47; i >= 0; i--) q_bits.push_back(model[i]);

        cmd_valid   = 1'b1;
        cmd_index   = idx;
        cmd_arg     = arg;
        sd_clk_fall = acc_strobe;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b0;
        sd_clk_fall = 1'b0;
        cmd_index   = ~idx;
        cmd_arg     = ~arg;
        check({tag, "/busy_after_accept"}, 64'(busy), 64'd1);
        check({tag, "/ready_after_accept"}, 64'(cmd_ready), 64'd0);

        got       = '0;
        done_n    = 0;
        ready_bad = 1'b0;
        for (int n = 1; n <= 70 && done_n == 0; n++) begin
            strobe(n == abort_at);
            if (n == abort_at) begin
                check({tag, "/abort_oe"}, 64'(cmd_oe), 64'd0);
                check({tag, "/abort_out"}, 64'(cmd_out), 64'd1);
                check({tag, "/abort_ready"}, 64'(cmd_ready), 64'd1);
                check({tag, "/abort_done"}, 64'(done), 64'd0);
                q_bits.delete();
                for (int k = 0; k < 60; k++) begin
                    strobe(1'b0);
                    if (done !== 1'b0) ready_bad = 1'b1;
                end
                check({tag, "/no_done_after_abort"}, 64'(ready_bad), 64'd0);
                return;
            end
            if (n <= 48) begin
                exp_bit = q_bits.pop_front();
                check({tag, "/line_bit"}, 64'({cmd_oe, cmd_out}), 64'({1'b1, exp_bit}));
                got = {got[46:0], cmd_out};
            end else if (n == 49) begin
                check({tag, "/release"}, 64'({cmd_oe, cmd_out}), 64'b01);
            end
            if (done === 1'b1) done_n = n;
            else if (cmd_ready !== 1'b0) ready_bad = 1'b1;
        end
        check({tag, "/frame"}, 64'(got), 64'(exp_frame));
        check({tag, "/done_strobe"}, 64'(done_n), 64'd57);
        check({tag, "/ready_low_while_busy"}, 64'(ready_bad), 64'd0);
        check({tag, "/ready_with_done"}, 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "/done_one_cycle"}, 64'(done), 64'd0);
    endtask

    initial begin
        logic [47:0] frame;
        logic [47:0] got1, got2;
        int          done2_n;
        vectors     = 0;
        miscompares = 0;
        res         = 1'b1;
        sd_clk_fall = 1'b0;
        cmd_valid   = 1'b0;
        cmd_index   = '0;
        cmd_arg     = '0;
        cmd_valid_b = 1'b0;
        cmd_index_b = '0;
        cmd_arg_b   = '0;
        repeat (3) @(posedge clk);
        #1;
        res = 1'b0;
        check("reset/ready", 64'(cmd_ready), 64'd1);
        check("reset/out", 64'(cmd_out), 64'd1);
        check("reset/oe", 64'(cmd_oe), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
`ifdef SD_CMD_TX_CNT_EN
        check("reset/tx_count", 64'(tx_count), 64'd0);
`endif

        // idle strobes must not start anything
        strobe(1'b0);
        check("idle_strobe/oe", 64'({cmd_oe, busy}), 64'd0);

        run_frame("cmd0", 6'd0, 32'h0000_0000, 1'b0, 0, 48'h40_0000_0000_95, frame);
        run_frame("cmd8", 6'd8, 32'h0000_01AA, 1'b0, 0, 48'h48_0000_01AA_87, frame);
        check("cmd8/crc_field", 64'(frame[7:1]), 64'h43);
        run_frame("cmd17", 6'd17, 32'h0000_0000, 1'b1, 0, 48'h51_0000_0000_55, frame);
        check("cmd17/last_byte", 64'(frame[7:0]), 64'h55);
        run_frame("cmd55_abort", 6'd55, 32'h0000_0000, 1'b0, 20, 48'h77_0000_0000_65, frame);
        run_frame("cmd0_after_abort", 6'd0, 32'h0000_0000, 1'b0, 0, 48'h40_0000_0000_95, frame);
`ifdef SD_CMD_TX_CNT_EN
        check("a/tx_count", 64'(tx_count), 64'd1);
`endif

        // GAP_BITS=0 instance, valid held across two commands
        cmd_valid_b = 1'b1;
        cmd_index_b = 6'd0;
        cmd_arg_b   = 32'h0;
        @(posedge clk);
        #1;
        cmd_index_b = 6'd8;
        cmd_arg_b   = 32'h0000_01AA;
        got1    = '0;
        got2    = '0;
        done2_n = 0;
        for (int n = 1; n <= 110; n++) begin
            strobe(1'b0);
            if (n <= 48) got1 = {got1[46:0], cmd_out_b};
            if (n >= 50 && n <= 97) got2 = {got2[46:0], cmd_out_b};
            if (n == 49) check("b/done_first", 64'(done_b), 64'd1);
            if (n == 50) check("b/second_start", 64'({cmd_oe_b, cmd_out_b}), 64'b10);
            if (n > 49 && done_b === 1'b1) begin
                done2_n     = n;
                cmd_valid_b = 1'b0;
                break;
            end
        end
        check("b/frame1", 64'(got1), 64'h40_0000_0000_95);
        check("b/frame2", 64'(got2), 64'h48_0000_01AA_87);
        check("b/done_second", 64'(done2_n), 64'd98);
`ifdef SD_CMD_TX_CNT_EN
        check("b/tx_count", 64'(tx_count_b), 64'd2);
`endif
        repeat (8) @(posedge clk);
        #1;
        check("b/idle_at_end", 64'({busy_b, cmd_ready_b}), 64'b01);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
